// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one CPOL0/CPHA0 byte engine across N_REQ SPI clients, with CS setup/gap timing.
// Latency: grant 1 cycle after request seen in IDLE; handshake->eng_start_o +1; eng_done_i->rx_valid_o +1.
// Backpressure: tx_ready_o only to the owner, only in WAIT; an in-flight byte is never cut.
module spi_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]   gnt_o,
  input  logic [N_REQ-1:0]   tx_valid_i,
  input  logic [N_REQ*8-1:0] tx_data_i,
  input  logic [N_REQ-1:0]   tx_last_i,
  output logic [N_REQ-1:0]   tx_ready_o,
  output logic [N_REQ-1:0]   rx_valid_o,
  output logic [7:0]         rx_data_o,
  output logic [N_REQ-1:0]   done_o,
  output logic [N_REQ-1:0]   ss_n_o,
  output logic               eng_start_o,
  output logic [7:0]         eng_tx_o,
  input  logic               eng_done_i,
  input  logic [7:0]         eng_rx_i
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, XFER, GAP} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    owner, rr, pick;
  logic             pick_vld;
  logic [CW-1:0]    cnt;
  logic             last_q;
  logic [N_REQ-1:0] owner_oh;

  assign owner_oh = N_REQ'(1) << owner;

  // Scan offsets from far to near so the requester closest after rr wins.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr) + k) % N_REQ;
      if (req_i[IW'(idx)]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    gnt_o      = '0;
    tx_ready_o = '0;
    unique case (state)
      IDLE:  if (pick_vld) state_nxt = SETUP;
      SETUP: begin
        gnt_o = owner_oh;
        if (cnt == CW'(CS_SETUP - 1)) state_nxt = WAIT;
      end
      WAIT: begin
        gnt_o      = owner_oh;
        tx_ready_o = owner_oh;
        if (!req_i[owner])          state_nxt = GAP;
        else if (tx_valid_i[owner]) state_nxt = XFER;
      end
      XFER: begin
        gnt_o = owner_oh;
        if (eng_done_i) state_nxt = last_q ? GAP : WAIT;
      end
      GAP:     if (cnt == CW'(CS_GAP - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Selects derive from state, so an async reset releases CS immediately.
  assign ss_n_o = ~gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner       <= '0;
      rr          <= IW'(N_REQ - 1);
      cnt         <= '0;
      last_q      <= 1'b0;
      eng_tx_o    <= '0;
      eng_start_o <= 1'b0;
      rx_valid_o  <= '0;
      rx_data_o   <= '0;
      done_o      <= '0;
    end else begin
      eng_start_o <= 1'b0;
      rx_valid_o  <= '0;
      done_o      <= '0;

      if (state_nxt != state)                cnt <= '0;
      else if (state == SETUP || state == GAP) cnt <= cnt + 1'b1;

      if (state == IDLE && pick_vld) begin
        owner <= pick;
        rr    <= pick;
      end

      if (state == WAIT) begin
        if (!req_i[owner]) begin
          done_o <= owner_oh;
        end else if (tx_valid_i[owner]) begin
          eng_tx_o    <= tx_data_i[{owner, 3'b000} +: 8];
          last_q      <= tx_last_i[owner];
          eng_start_o <= 1'b1;
        end
      end

      if (state == XFER && eng_done_i) begin
        rx_valid_o <= owner_oh;
        rx_data_o  <= eng_rx_i;
        if (last_q) done_o <= owner_oh;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed + randomized bench for spi_bus_arbiter: client driver, engine model and
// a transaction-level round-robin/byte-stream reference with timing monitors.
module tb_spi_bus_arbiter;
  localparam int N = 3, CS_SETUP = 2, CS_GAP = 4;
  localparam logic [N-1:0] ALL1 = '1;
  localparam logic [N-1:0] ZERO = '0;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_i, tx_valid_i, tx_last_i;
  logic [N*8-1:0] tx_data_i;
  logic [N-1:0]   gnt_o, tx_ready_o, rx_valid_o, done_o, ss_n_o;
  logic [7:0]     rx_data_o, eng_tx_o, eng_rx_i;
  logic           eng_start_o, eng_done_i;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rise_cyc = 0, fall_cyc = 0, n_start = 0;
  bit seen_rise = 1'b0, start_pending = 1'b0;
  logic [N-1:0] ss_prev = '1, mon_ngnt;
  logic [7:0] exp_tx_q[$], exp_rx_q[$];
  int eng_lo = 1, eng_hi = 4, eng_d;
  bit eng_fixed = 1'b0, eng_ab;
  logic [7:0] eng_val = 8'h00, eng_cap;
  int rr_model, exp_o, t;
  logic [N-1:0] oh6;

  spi_bus_arbiter #(.N_REQ(N), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_last_i(tx_last_i),
    .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .done_o(done_o), .ss_n_o(ss_n_o), .eng_start_o(eng_start_o),
    .eng_tx_o(eng_tx_o), .eng_done_i(eng_done_i), .eng_rx_i(eng_rx_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // First requester strictly after the last owner, circularly.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Engine model: random latency, checks the byte it was handed and its stability.
  initial begin
    eng_done_i = 1'b0;
    eng_rx_i   = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (eng_start_o) begin
        eng_cap = eng_tx_o;
        chk("eng_tx_queued", exp_tx_q.size() > 0, 1);
        if (exp_tx_q.size() > 0) chk("eng_tx", eng_cap, exp_tx_q.pop_front());
        eng_d  = $urandom_range(eng_hi, eng_lo);
        eng_ab = 1'b0;
        for (int k = 0; k < eng_d; k++) begin
          @(posedge clk_i);
          if (!rst_ni) begin
            eng_ab = 1'b1;
            break;
          end
          #2;
          chk("eng_tx_stable", eng_tx_o, eng_cap);
        end
        if (!eng_ab) begin
          eng_rx_i = eng_fixed ? eng_val : 8'($urandom);
          exp_rx_q.push_back(eng_rx_i);
          eng_done_i = 1'b1;
          @(posedge clk_i);
          #1;
          eng_done_i = 1'b0;
        end
      end
    end
  end

  // Bus invariants and CS timing, sampled on the falling edge.
  always @(negedge clk_i) begin
    cyc++;
    mon_ngnt = ~gnt_o;
    chk("gnt_onehot0", $onehot0(gnt_o), 1);
    chk("ss_matches_gnt", ss_n_o, mon_ngnt);
    if (ss_n_o != ALL1 && ss_prev == ALL1) begin
      if (seen_rise) chk("cs_gap", (cyc - rise_cyc) >= CS_GAP, 1);
      fall_cyc      = cyc;
      start_pending = 1'b1;
    end
    if (ss_n_o == ALL1 && ss_prev != ALL1) begin
      rise_cyc  = cyc;
      seen_rise = 1'b1;
    end
    if (eng_start_o) begin
      n_start++;
      if (start_pending) chk("cs_setup", (cyc - fall_cyc) >= CS_SETUP + 1, 1);
      start_pending = 1'b0;
    end
    ss_prev = ss_n_o;
  end

  task automatic serve(input int o, input int nbytes, input int drop_after, input bit cmd);
    logic [N-1:0] oh, noh;
    logic [7:0] b, r;
    int tt, s0;
    bit lst;
    oh = '0;
    oh[o] = 1'b1;
    noh = ~oh;
    s0 = n_start;
    tt = 0;
    while (gnt_o == ZERO && tt < 100) begin step(); tt++; end
    chk("grant", gnt_o, oh);
    chk("ss_select", ss_n_o, noh);
    for (int i = 0; i < nbytes; i++) begin
      lst = (i == nbytes - 1);
      tt = 0;
      while (!tx_ready_o[o] && tt < 100) begin step(); tt++; end
      chk("tx_ready", tx_ready_o, oh);
      if (cmd) b = (i == 0) ? 8'h03 : (i < 4) ? 8'h00 : 8'($urandom);
      else     b = 8'($urandom);
      tx_valid_i[o] = 1'b1;
      tx_data_i[8*o +: 8] = b;
      tx_last_i[o] = lst;
      exp_tx_q.push_back(b);
      step();
      tx_valid_i[o] = 1'b0;
      tx_last_i[o]  = 1'b0;
      chk("eng_start", eng_start_o, 1);
      chk("ready_busy", tx_ready_o, ZERO);
      tt = 0;
      while (!rx_valid_o[o] && tt < 100) begin step(); tt++; end
      chk("rx_valid", rx_valid_o, oh);
      r = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 8'hxx;
      chk("rx_data", rx_data_o, r);
      chk("rx_ready", tx_ready_o, lst ? ZERO : oh);
      chk("done", done_o, lst ? oh : ZERO);
      chk("ss_hold", ss_n_o, lst ? ALL1 : noh);
      if (!lst && drop_after == i + 1) begin
        req_i[o] = 1'b0;
        step();
        chk("abort_done", done_o, oh);
        chk("abort_ss", ss_n_o, ALL1);
        repeat (8) begin
          step();
          chk("abort_no_start", eng_start_o, 0);
        end
        chk("abort_starts", n_start - s0, i + 1);
        return;
      end
    end
    chk("start_count", n_start - s0, nbytes);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every client requesting.
    rst_ni = 1'b0;
    req_i = '1;
    tx_valid_i = '0;
    tx_last_i = '0;
    tx_data_i = '0;
    repeat (3) begin
      step();
      chk("rst_ss", ss_n_o, ALL1);
      chk("rst_gnt", gnt_o, ZERO);
      chk("rst_ready", tx_ready_o, ZERO);
      chk("rst_rx_valid", rx_valid_o, ZERO);
      chk("rst_done", done_o, ZERO);
      chk("rst_start", eng_start_o, 0);
      chk("rst_eng_tx", eng_tx_o, 0);
      chk("rst_rx_data", rx_data_o, 0);
    end
    rst_ni = 1'b1;
    rr_model = N - 1;

    // Flash read command with the engine echoing 0xA5.
    eng_fixed = 1'b1;
    eng_val = 8'hA5;
    exp_o = rr_pick(req_i, rr_model);
    rr_model = exp_o;
    serve(exp_o, 8, 0, 1'b1);
    eng_fixed = 1'b0;

    // All clients keep requesting: rotation continues.
    for (int k = 0; k < 5; k++) begin
      exp_o = rr_pick(req_i, rr_model);
      rr_model = exp_o;
      serve(exp_o, 1 + int'($urandom_range(2, 0)), 0, 1'b0);
    end

    // Client 2 abandons after one byte.
    req_i = 3'b100;
    exp_o = rr_pick(req_i, rr_model);
    rr_model = exp_o;
    serve(exp_o, 3, 1, 1'b0);

    // Reset while a byte is in flight, then a clean transaction.
    eng_lo = 8;
    eng_hi = 8;
    req_i = 3'b010;
    exp_o = rr_pick(req_i, rr_model);
    rr_model = exp_o;
    oh6 = '0;
    oh6[exp_o] = 1'b1;
    t = 0;
    while (gnt_o == ZERO && t < 100) begin step(); t++; end
    chk("r6_grant", gnt_o, oh6);
    t = 0;
    while (!tx_ready_o[exp_o] && t < 100) begin step(); t++; end
    chk("r6_ready", tx_ready_o, oh6);
    tx_valid_i[exp_o] = 1'b1;
    tx_data_i[8*exp_o +: 8] = 8'h5A;
    exp_tx_q.push_back(8'h5A);
    step();
    tx_valid_i = '0;
    chk("r6_start", eng_start_o, 1);
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("r6_async_ss", ss_n_o, ALL1);
    chk("r6_async_gnt", gnt_o, ZERO);
    chk("r6_async_start", eng_start_o, 0);
    chk("r6_async_eng_tx", eng_tx_o, 0);
    repeat (5) step();
    rst_ni = 1'b1;
    rr_model = N - 1;
    eng_lo = 1;
    eng_hi = 4;
    exp_o = rr_pick(req_i, rr_model);
    rr_model = exp_o;
    serve(exp_o, 4, 0, 1'b0);
    req_i = '0;
    repeat (10) step();
    chk("end_idle_ss", ss_n_o, ALL1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
